rx_comb_ctrl: RTL and testbench
===============================

Name: rx_comb_ctrl

Overview:
Sequencing controller for the 4-chain MIMO receive combiner, in the CLK_2 (decimated) domain after the per-chain RX_CHAIN outputs.
- Holds the per-chain enable configuration and gates disabled chains out of the I/Q sum.
- Blanks the output while chain filters settle after start, then produces a registered combined I/Q stream with a valid strobe.
- Flushes cleanly on stop.

Parameters:
N_CH, 4, number of receive chains (the design is verified at 4 only).
W_IN, 6, signed width of each chain I/Q sample.
W_OUT, 8, signed width of the combined output; must be at least W_IN+clog2(N_CH).
WARMUP_CYC, 16, CLK_2 cycles of output blanking after START; range 1..255.

Ports:
CLK_2  in  1  combiner clock.
RST  in  1  reset, asynchronous, active-low.
START  in  1  single-cycle pulse; begins a reception run.
STOP  in  1  single-cycle pulse; ends the run.
CFG_WE  in  1  write strobe for CH_EN_CFG.
CH_EN_CFG  in  N_CH  per-chain enable; bit k selects chain k+1.
I_CWM_BUS  in  N_CH*W_IN  chain I samples; chain k occupies bits [k*W_IN +: W_IN].
Q_CWM_BUS  in  N_CH*W_IN  chain Q samples, same packing.
CH_MASK  out  N_CH  active chain mask, as latched.
BUSY  out  1  high in WARMUP, RUN and FLUSH.
STATE  out  2  IDLE=0, WARMUP=1, RUN=2, FLUSH=3.
I_TOTAL  out  W_OUT  combined I.
Q_TOTAL  out  W_OUT  combined Q.
OUT_VALID  out  1  I_TOTAL/Q_TOTAL hold a valid combined sample.

Behaviour:
- Reset: STATE=IDLE, CH_MASK=4'b1111, warm-up counter=0, I_TOTAL=0, Q_TOTAL=0, OUT_VALID=0, BUSY=0. Reset mid-run aborts immediately with no flush.
- Config: CFG_WE is honoured only in IDLE and loads CH_MASK the next cycle. It is ignored in every other state, so the mask is stable for the whole run.
- IDLE:
  - START with STOP low and effective mask nonzero -> WARMUP; counter loads WARMUP_CYC-1.
  - START with mask zero is ignored.
  - START and STOP in the same cycle: STOP wins, remain in IDLE.
  - CFG_WE together with START: the new mask is used. The effective mask is CH_EN_CFG when CFG_WE=1, otherwise CH_MASK.
- WARMUP:
  - Counter decrements each cycle; when it reaches 0 -> RUN. WARMUP therefore lasts exactly WARMUP_CYC cycles.
  - OUT_VALID=0.
  - STOP -> IDLE directly; no output was produced.
  - START is ignored.
- RUN:
  - Each cycle, register I_TOTAL = sum over k of (CH_MASK[k] ? sign_ext(I_k) : 0), and likewise Q_TOTAL. OUT_VALID=1 is registered with them.
  - Latency is 1 CLK_2 cycle from bus input to output.
  - Sum uses a balanced adder tree ((0+1)+(2+3)) with sign extension to W_OUT. No overflow is possible at the defaults (range -128..+124), so there is no saturation.
  - STOP -> FLUSH; the sample presented in the STOP cycle is still combined and output.
  - START is ignored.
- FLUSH:
  - Lasts one cycle; OUT_VALID=0 -> IDLE.
  - I_TOTAL/Q_TOTAL hold their last value; they are not cleared.
- First valid output is on the cycle after the first RUN cycle.
- OUT_VALID is never high outside RUN plus one registered cycle. Specifically, OUT_VALID goes low in the FLUSH cycle.

Optional Feature:
RX_COMB_PEAK_EN:
- When defined, adds outputs PEAK_I and PEAK_Q (W_OUT-1 bits, unsigned).
- They hold the maximum |I_TOTAL| and |Q_TOTAL| over all valid outputs of the current run.
- Cleared to 0 on the WARMUP->RUN transition and at reset; held in IDLE.
- Abs(-128) saturates to 127.
- When undefined, the ports and logic are absent and the module is otherwise identical.

Decomposition:
- Package rx_comb_pkg:
  - State encoding constants: ST_IDLE, ST_WARMUP, ST_RUN, ST_FLUSH.
  - Default N_CH, W_IN, W_OUT.
  - Function for the minimum W_OUT check.
- One sub-module, rx_masked_adder_tree: combinational masked sign-extend and 3-adder tree, instantiated twice (I and Q). The FSM and registers stay in rx_comb_ctrl.

Test Plan:
1. Reset then idle: no START -> OUT_VALID=0, I_TOTAL=0, CH_MASK=4'b1111, STATE=0.
2. Mask 1111, WARMUP_CYC=16, START; chains I = 5,-3,7,-2 and Q = -31,-32,-32,-32 -> OUT_VALID rises exactly 17 cycles after START; I_TOTAL=7, Q_TOTAL=-127.
3. CFG_WE with 4'b0101 in IDLE, then START; I = 10,20,-5,30 -> I_TOTAL=5. CFG_WE=4'b1111 during RUN -> CH_MASK unchanged.
4. START with mask 0000 -> stays IDLE. START and STOP in the same cycle -> stays IDLE.
5. STOP in the 5th WARMUP cycle -> IDLE next cycle, OUT_VALID never asserted. STOP in RUN -> one final valid sample, then FLUSH (OUT_VALID=0), then IDLE.
6. RST low mid-RUN -> all outputs reset asynchronously. With RX_COMB_PEAK_EN, outputs I = -128 then 50 -> PEAK_I=127.

Source files
------------

// File: rtl/rx_comb_pkg.sv
// Shared constants for the 4-chain MIMO receive combiner controller.
// Optional peak tracking is enabled with RX_COMB_PEAK_EN.
package rx_comb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WARMUP = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_FLUSH  = 2'd3;

  localparam int DEF_N_CH   = 4;
  localparam int DEF_W_IN   = 6;
  localparam int DEF_W_OUT  = 8;
  localparam int DEF_WARMUP = 16;

  function automatic int min_w_out(input int n_ch, input int w_in);
    return w_in + $clog2(n_ch);
  endfunction

endpackage

// File: rtl/rx_masked_adder_tree.sv
// Masked sign-extending sum of the per-chain samples.
// Four chains use the balanced (0+1)+(2+3) tree.
module rx_masked_adder_tree
  import rx_comb_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int W_IN  = DEF_W_IN,
  parameter int W_OUT = DEF_W_OUT
) (
  input  logic [N_CH-1:0]      mask,
  input  logic [N_CH*W_IN-1:0] bus,
  output logic [W_OUT-1:0]     sum
);

  logic [W_OUT-1:0] term [N_CH];

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      term[k] = '0;
      if (mask[k])
        term[k] = {{(W_OUT-W_IN){bus[k*W_IN+W_IN-1]}},
                   bus[k*W_IN +: W_IN]};
    end
  end

  if (N_CH == 4) begin : g_tree
    logic [W_OUT-1:0] s01;
    logic [W_OUT-1:0] s23;
    assign s01 = term[0] + term[1];
    assign s23 = term[2] + term[3];
    assign sum = s01 + s23;
  end else begin : g_chain
    logic [W_OUT-1:0] acc;
    always_comb begin
      acc = '0;
      for (int k = 0; k < N_CH; k++)
        acc = acc + term[k];
    end
    assign sum = acc;
  end

endmodule

// File: rtl/rx_comb_ctrl.sv
// Receive combiner sequencer: mask config, warm-up blanking, run, flush.
// Define RX_COMB_PEAK_EN to add PEAK_I / PEAK_Q magnitude tracking.
module rx_comb_ctrl
  import rx_comb_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int W_IN       = DEF_W_IN,
  parameter int W_OUT      = DEF_W_OUT,
  parameter int WARMUP_CYC = DEF_WARMUP
) (
  input  logic                 CLK_2,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 STOP,
  input  logic                 CFG_WE,
  input  logic [N_CH-1:0]      CH_EN_CFG,
  input  logic [N_CH*W_IN-1:0] I_CWM_BUS,
  input  logic [N_CH*W_IN-1:0] Q_CWM_BUS,
  output logic [N_CH-1:0]      CH_MASK,
  output logic                 BUSY,
  output logic [1:0]           STATE,
  output logic [W_OUT-1:0]     I_TOTAL,
  output logic [W_OUT-1:0]     Q_TOTAL,
  output logic                 OUT_VALID
`ifdef RX_COMB_PEAK_EN
  ,
  output logic [W_OUT-2:0]     PEAK_I,
  output logic [W_OUT-2:0]     PEAK_Q
`endif
);

  if (W_OUT < min_w_out(N_CH, W_IN)) begin : g_bad_w
    $error("rx_comb_ctrl: W_OUT too narrow");
  end
  if (WARMUP_CYC < 1 || WARMUP_CYC > 255) begin : g_bad_wu
    $error("rx_comb_ctrl: WARMUP_CYC out of range");
  end

  logic [1:0]       state;
  logic [7:0]       cnt;
  logic [N_CH-1:0]  eff_mask;
  logic [W_OUT-1:0] i_sum;
  logic [W_OUT-1:0] q_sum;
  logic             go;
  logic             run_entry;

  assign eff_mask  = CFG_WE ? CH_EN_CFG : CH_MASK;
  assign go        = START && !STOP && (|eff_mask);
  assign run_entry = (state == ST_WARMUP) && !STOP && (cnt == 8'd0);
  assign STATE     = state;
  assign BUSY      = (state != ST_IDLE);

  rx_masked_adder_tree #(
    .N_CH(N_CH), .W_IN(W_IN), .W_OUT(W_OUT)
  ) u_tree_i (
    .mask(CH_MASK), .bus(I_CWM_BUS), .sum(i_sum)
  );

  rx_masked_adder_tree #(
    .N_CH(N_CH), .W_IN(W_IN), .W_OUT(W_OUT)
  ) u_tree_q (
    .mask(CH_MASK), .bus(Q_CWM_BUS), .sum(q_sum)
  );

  always_ff @(posedge CLK_2 or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      CH_MASK   <= '1;
      I_TOTAL   <= '0;
      Q_TOTAL   <= '0;
      OUT_VALID <= 1'b0;
    end else begin
      OUT_VALID <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (CFG_WE) CH_MASK <= CH_EN_CFG;
          if (go) begin
            state <= ST_WARMUP;
            cnt   <= 8'(WARMUP_CYC - 1);
          end
        end
        ST_WARMUP: begin
          if (STOP)
            state <= ST_IDLE;
          else if (cnt == 8'd0)
            state <= ST_RUN;
          else
            cnt <= cnt - 8'd1;
        end
        ST_RUN: begin
          // the STOP-cycle sample is still combined
          I_TOTAL   <= i_sum;
          Q_TOTAL   <= q_sum;
          OUT_VALID <= 1'b1;
          if (STOP) state <= ST_FLUSH;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef RX_COMB_PEAK_EN
  function automatic logic [W_OUT-2:0] mag(input logic [W_OUT-1:0] v);
    logic [W_OUT-1:0] n;
    n = -v;
    if (!v[W_OUT-1])
      return v[W_OUT-2:0];
    else if (v[W_OUT-2:0] == '0)
      return '1;
    else
      return n[W_OUT-2:0];
  endfunction

  logic [W_OUT-2:0] mag_i;
  logic [W_OUT-2:0] mag_q;

  assign mag_i = mag(i_sum);
  assign mag_q = mag(q_sum);

  // tracks the value being registered so peak aligns with I/Q_TOTAL
  always_ff @(posedge CLK_2 or negedge RST) begin
    if (!RST) begin
      PEAK_I <= '0;
      PEAK_Q <= '0;
    end else if (run_entry) begin
      PEAK_I <= '0;
      PEAK_Q <= '0;
    end else if (state == ST_RUN) begin
      if (mag_i > PEAK_I) PEAK_I <= mag_i;
      if (mag_q > PEAK_Q) PEAK_Q <= mag_q;
    end
  end
`endif

endmodule

// File: tb/tb_rx_comb_ctrl.sv
// Directed self-checking bench for rx_comb_ctrl.
// Peak checks are compiled in when RX_COMB_PEAK_EN is defined.
module tb_rx_comb_ctrl;

  logic        CLK_2 = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic        STOP = 1'b0;
  logic        CFG_WE = 1'b0;
  logic [3:0]  CH_EN_CFG = '0;
  logic [23:0] I_CWM_BUS = '0;
  logic [23:0] Q_CWM_BUS = '0;
  logic [3:0]  CH_MASK;
  logic        BUSY;
  logic [1:0]  STATE;
  logic [7:0]  I_TOTAL;
  logic [7:0]  Q_TOTAL;
  logic        OUT_VALID;
`ifdef RX_COMB_PEAK_EN
  logic [6:0]  PEAK_I;
  logic [6:0]  PEAK_Q;
`endif

  rx_comb_ctrl dut (
    .CLK_2(CLK_2),
    .RST(RST),
    .START(START),
    .STOP(STOP),
    .CFG_WE(CFG_WE),
    .CH_EN_CFG(CH_EN_CFG),
    .I_CWM_BUS(I_CWM_BUS),
    .Q_CWM_BUS(Q_CWM_BUS),
    .CH_MASK(CH_MASK),
    .BUSY(BUSY),
    .STATE(STATE),
    .I_TOTAL(I_TOTAL),
    .Q_TOTAL(Q_TOTAL),
    .OUT_VALID(OUT_VALID)
`ifdef RX_COMB_PEAK_EN
    ,
    .PEAK_I(PEAK_I),
    .PEAK_Q(PEAK_Q)
`endif
  );

  always #5 CLK_2 = ~CLK_2;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [23:0] pk(input int a, input int b,
                                     input int c, input int d);
    return {6'(d), 6'(c), 6'(b), 6'(a)};
  endfunction

  task automatic step();
    @(negedge CLK_2);
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    while (!OUT_VALID && c < 40) begin
      step();
      c++;
    end
  endtask

  int c;
  logic seen;

  initial begin
    // reset state
    #12;
    chk("rst_state", 32'(STATE), 32'd0);
    chk("rst_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_itot", 32'(I_TOTAL), 32'd0);
    chk("rst_mask", 32'(CH_MASK), 32'hf);
    step();
    RST = 1'b1;
    step();
    step();
    chk("idle_state", 32'(STATE), 32'd0);
    chk("idle_valid", 32'(OUT_VALID), 32'd0);

    // full mask run, latency from START
    I_CWM_BUS = pk(5, -3, 7, -2);
    Q_CWM_BUS = pk(-31, -32, -32, -32);
    START = 1'b1;
    step();
    START = 1'b0;
    chk("warm_state", 32'(STATE), 32'd1);
    chk("warm_busy", 32'(BUSY), 32'd1);
    wait_valid(c);
    chk("latency", 32'(c), 32'd17);
    chk("run_itot", 32'(I_TOTAL), 32'h07);
    chk("run_qtot", 32'(Q_TOTAL), 32'h81);
    chk("run_state", 32'(STATE), 32'd2);

    // STOP in RUN: last sample, flush, idle
    I_CWM_BUS = pk(1, 1, 1, 1);
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    chk("stop_valid", 32'(OUT_VALID), 32'd1);
    chk("stop_itot", 32'(I_TOTAL), 32'h04);
    chk("flush_state", 32'(STATE), 32'd3);
    step();
    chk("flush_valid", 32'(OUT_VALID), 32'd0);
    chk("post_state", 32'(STATE), 32'd0);
    chk("hold_itot", 32'(I_TOTAL), 32'h04);

    // partial mask
    CFG_WE = 1'b1;
    CH_EN_CFG = 4'b0101;
    step();
    CFG_WE = 1'b0;
    chk("cfg_mask", 32'(CH_MASK), 32'h5);
    I_CWM_BUS = pk(10, 20, -5, 30);
    Q_CWM_BUS = '0;
    START = 1'b1;
    step();
    START = 1'b0;
    wait_valid(c);
    chk("mask_lat", 32'(c), 32'd17);
    chk("mask_itot", 32'(I_TOTAL), 32'h05);
    CFG_WE = 1'b1;
    CH_EN_CFG = 4'b1111;
    step();
    CFG_WE = 1'b0;
    chk("run_cfg_mask", 32'(CH_MASK), 32'h5);
    chk("run_cfg_itot", 32'(I_TOTAL), 32'h05);
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    step();

    // zero mask and START+STOP
    CFG_WE = 1'b1;
    CH_EN_CFG = 4'b0000;
    START = 1'b1;
    step();
    CFG_WE = 1'b0;
    chk("zmask_state", 32'(STATE), 32'd0);
    chk("zmask_mask", 32'(CH_MASK), 32'h0);
    step();
    chk("zmask2_state", 32'(STATE), 32'd0);
    CFG_WE = 1'b1;
    CH_EN_CFG = 4'b1111;
    STOP = 1'b1;
    step();
    START = 1'b0;
    STOP = 1'b0;
    CFG_WE = 1'b0;
    chk("ss_state", 32'(STATE), 32'd0);
    chk("ss_mask", 32'(CH_MASK), 32'hf);

    // STOP in the 5th warm-up cycle
    START = 1'b1;
    step();
    START = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      step();
      seen |= OUT_VALID;
    end
    chk("wu4_state", 32'(STATE), 32'd1);
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    seen |= OUT_VALID;
    chk("wustop_state", 32'(STATE), 32'd0);
    chk("wustop_seen", 32'(seen), 32'd0);

    // negative full scale, then async reset mid-run
    I_CWM_BUS = pk(-32, -32, -32, -32);
    Q_CWM_BUS = '0;
    START = 1'b1;
    step();
    START = 1'b0;
    wait_valid(c);
    chk("neg_lat", 32'(c), 32'd17);
    chk("neg_itot", 32'(I_TOTAL), 32'h80);
    I_CWM_BUS = pk(20, 20, 10, 0);
    step();
    chk("pos_itot", 32'(I_TOTAL), 32'h32);
`ifdef RX_COMB_PEAK_EN
    chk("peak_i", 32'(PEAK_I), 32'd127);
    chk("peak_q", 32'(PEAK_Q), 32'd0);
`endif
    #2;
    RST = 1'b0;
    #1;
    chk("arst_state", 32'(STATE), 32'd0);
    chk("arst_valid", 32'(OUT_VALID), 32'd0);
    chk("arst_busy", 32'(BUSY), 32'd0);
    chk("arst_itot", 32'(I_TOTAL), 32'd0);
    chk("arst_mask", 32'(CH_MASK), 32'hf);
`ifdef RX_COMB_PEAK_EN
    chk("arst_peak", 32'(PEAK_I), 32'd0);
`endif
    RST = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
